// File: rtl/array_ex_pkg.sv
// Shared definitions for the array_ex bus initiator.
//   - default data/address widths and array depth
//   - FSM state type for array_ex_master
//   - command op encoding
package array_ex_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned DEPTH      = 1 << ADDR_W_DEF;

  localparam logic OP_FILL = 1'b1;
  localparam logic OP_DUMP = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BEAT  = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RD_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/array_ex_addr_gen.sv
// Word index / remaining-count tracker for array_ex_master.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture base, cnt and seed; index restarts at 0
//   step       : advance to the next word
//   base, cnt, seed : command parameters (cnt already clamped, non-zero)
//   next_addr  : base + index + 1 (wraps), address of the following word
//   next_data  : seed + index + 1 (wraps), fill data of the following word
//   last       : the current word is the final one of the command
module array_ex_addr_gen
  import array_ex_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   cnt,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] next_addr,
  output logic [DATA_W-1:0] next_data,
  output logic              last
);

  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      seed_q    <= '0;
      idx       <= '0;
      remaining <= '0;
    end else if (load) begin
      base_q    <= base;
      seed_q    <= seed;
      idx       <= '0;
      remaining <= cnt;
    end else if (step) begin
      idx       <= idx + ADDR_W'(1);
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end

  // The master registers its bus outputs, so it needs the following
  // word's address/data one cycle ahead of the beat.
  assign next_addr = base_q + idx + ADDR_W'(1);
  assign next_data = seed_q + DATA_W'(idx) + DATA_W'(1);
  assign last      = (remaining == (ADDR_W+1)'(1));

endmodule

// File: rtl/array_ex_master.sv
// Bus initiator for the array_ex register array.
// Fill (op=1) writes fill_data+i to base_addr+i; dump (op=0) reads
// base_addr+i and presents each word on a valid/ready stream.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, op, base_addr, count, fill_data : command (sampled when idle)
//   busy, done          : command in progress / one-cycle completion pulse
//   addr, wr, sel, wdata, rdata : array bus (rdata valid the cycle after a read)
//   out_valid, out_data, out_ready : dump output stream
module array_ex_master
  import array_ex_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic              sel,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);

  state_t            state, nxt_state;
  logic [ADDR_W:0]   eff_cnt;
  logic              gen_load, gen_step, gen_last;
  logic [ADDR_W-1:0] gen_addr;
  logic [DATA_W-1:0] gen_data;

  logic              nxt_sel, nxt_wr, nxt_out_valid;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_wdata, nxt_out_data;

  assign eff_cnt = (count > DEPTH_C) ? DEPTH_C : count;

  array_ex_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (gen_load),
    .step      (gen_step),
    .base      (base_addr),
    .cnt       (eff_cnt),
    .seed      (fill_data),
    .next_addr (gen_addr),
    .next_data (gen_data),
    .last      (gen_last)
  );

  // Next-state logic also computes the next value of every registered
  // output, so each output is a flop with no input-to-output path.
  always_comb begin
    nxt_state     = state;
    nxt_sel       = 1'b0;
    nxt_wr        = 1'b0;
    nxt_addr      = addr;
    nxt_wdata     = wdata;
    nxt_out_valid = 1'b0;
    nxt_out_data  = out_data;
    gen_load      = 1'b0;
    gen_step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (eff_cnt == '0) begin
            nxt_state = DONE;
          end else begin
            gen_load = 1'b1;
            nxt_sel  = 1'b1;
            nxt_addr = base_addr;
            if (op == OP_FILL) begin
              nxt_state = WR_BEAT;
              nxt_wr    = 1'b1;
              nxt_wdata = fill_data;
            end else begin
              nxt_state = RD_ISSUE;
            end
          end
        end
      end
      WR_BEAT: begin
        gen_step = 1'b1;
        if (gen_last) begin
          nxt_state = DONE;
        end else begin
          nxt_sel   = 1'b1;
          nxt_wr    = 1'b1;
          nxt_addr  = gen_addr;
          nxt_wdata = gen_data;
        end
      end
      RD_ISSUE: nxt_state = RD_CAPT;
      RD_CAPT: begin
        nxt_out_data  = rdata;
        nxt_out_valid = 1'b1;
        nxt_state     = RD_HOLD;
      end
      RD_HOLD: begin
        // out_valid is always high here, so out_ready alone is the handshake
        if (out_ready) begin
          gen_step = 1'b1;
          if (gen_last) begin
            nxt_state = DONE;
          end else begin
            nxt_state = RD_ISSUE;
            nxt_sel   = 1'b1;
            nxt_addr  = gen_addr;
          end
        end else begin
          nxt_out_valid = 1'b1;
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel       <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= nxt_state;
      busy      <= (nxt_state != IDLE);
      done      <= (nxt_state == DONE);
      sel       <= nxt_sel;
      wr        <= nxt_wr;
      addr      <= nxt_addr;
      wdata     <= nxt_wdata;
      out_valid <= nxt_out_valid;
      out_data  <= nxt_out_data;
    end
  end

endmodule

// File: tb/tb_array_ex_master.sv
// Self-checking bench for array_ex_master with a behavioural 4x16 array
// as the bus responder and a word-level reference model of the array.
module tb_array_ex_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [1:0]  base_addr = '0;
  logic [2:0]  count = '0;
  logic [15:0] fill_data = '0;
  logic        busy, done, wr, sel, out_valid;
  logic [1:0]  addr;
  logic [15:0] wdata, out_data;
  logic [15:0] rdata = '0;
  logic        out_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem   [4];
  logic [15:0] model [4];

  array_ex_master #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .base_addr (base_addr),
    .count     (count),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .addr      (addr),
    .wr        (wr),
    .sel       (sel),
    .wdata     (wdata),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Array responder: write on a write beat, registered read data.
  always @(posedge clk) begin
    if (sel) begin
      if (wr) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it cycle by cycle until done.
  // k counts cycles after the accepting edge (k=1 is the first busy cycle).
  task automatic run_cmd(input logic o, input logic [1:0] b, input logic [2:0] c,
                         input logic [15:0] s, input int hold, input bit poke);
    int n, done_k, beat_i, word_i, stalled, seen_w, exp_done;
    logic [1:0]  ea [4];
    logic [15:0] ed [4];
    n = (c > 3'd4) ? 4 : int'(c);
    for (int i = 0; i < n; i++) begin
      ea[i] = b + 2'(i);
      if (o) begin
        ed[i] = s + 16'(i);
        model[ea[i]] = ed[i];
      end else begin
        ed[i] = model[ea[i]];
      end
    end
    if (n == 0)  exp_done = 1;
    else if (o)  exp_done = n + 1;
    else         exp_done = 3 * n + hold + 1;

    @(negedge clk);
    op = o; base_addr = b; count = c; fill_data = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_k = -1; beat_i = 0; word_i = 0; stalled = 0; seen_w = -1;
    for (int k = 1; k <= 80 && done_k < 0; k++) begin
      if (k > 1) @(negedge clk);
      if (poke) begin
        if (k == 2) begin start = 1'b1; op = ~o; count = 3'd1; end
        else if (k == 3) start = 1'b0;
      end
      chk("busy", 32'(busy), 32'd1);
      if (sel) begin
        if (beat_i < n) begin
          chk("beat_k", 32'(k), o ? 32'(beat_i + 1) : 32'(1 + 3 * beat_i + stalled));
          chk("beat_wr", 32'(wr), 32'(o));
          chk("beat_addr", 32'(addr), 32'(ea[beat_i]));
          if (o) chk("beat_wdata", 32'(wdata), 32'(ed[beat_i]));
          beat_i++;
        end else begin
          chk("extra_beat", 32'(sel), 32'd0);
        end
      end
      if (out_valid) begin
        if (o || word_i >= n) begin
          chk("stray_valid", 32'(out_valid), 32'd0);
        end else begin
          if (seen_w != word_i) begin
            chk("valid_k", 32'(k), 32'(3 + 3 * word_i + stalled));
            seen_w = word_i;
          end
          chk("out_data", 32'(out_data), 32'(ed[word_i]));
          if (word_i == 0 && stalled < hold) begin
            out_ready = 1'b0;
            stalled++;
            chk("stall_no_beat", 32'(sel), 32'd0);
          end else begin
            out_ready = 1'b1;
            word_i++;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) done_k = k;
    end
    chk("done_k", 32'(done_k), 32'(exp_done));
    chk("beats", 32'(beat_i), 32'(n));
    if (!o) chk("words", 32'(word_i), 32'(n));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_odata", 32'(out_data), 32'd0);
    rst = 1'b0;

    // fill then dump the whole array
    run_cmd(1'b1, 2'd0, 3'd4, 16'hABCD, 0, 1'b0);
    run_cmd(1'b0, 2'd0, 3'd4, 16'h0000, 0, 1'b0);
    // wrap-around of address and data
    run_cmd(1'b1, 2'd3, 3'd2, 16'hFFFF, 0, 1'b0);
    run_cmd(1'b0, 2'd3, 3'd2, 16'h0000, 0, 1'b0);
    // backpressure on the first word
    run_cmd(1'b0, 2'd1, 3'd3, 16'h0000, 5, 1'b0);
    // zero count, oversize count, start while busy
    run_cmd(1'b1, 2'd2, 3'd0, 16'h1234, 0, 1'b0);
    run_cmd(1'b0, 2'd2, 3'd0, 16'h0000, 0, 1'b0);
    run_cmd(1'b1, 2'd1, 3'd7, 16'h5A00, 0, 1'b1);
    run_cmd(1'b0, 2'd0, 3'd6, 16'h0000, 0, 1'b0);

    // reset during the second beat of a 4-word fill
    @(negedge clk);
    op = 1'b1; base_addr = 2'd0; count = 3'd4; fill_data = 16'h7000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_sel", 32'(sel), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_wr", 32'(wr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      chk("rst_no_done", 32'(done), 32'd0);
    end
    run_cmd(1'b1, 2'd0, 3'd4, 16'h8001, 0, 1'b0);
    run_cmd(1'b0, 2'd0, 3'd4, 16'h0000, 0, 1'b0);

    // randomized fill/dump pairs
    for (int r = 0; r < 10; r++) begin
      run_cmd(1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              16'($urandom), 0, 1'b0);
      run_cmd(1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              16'd0, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
